mod3_div: RTL

Sequential signed divider, the inverse of the team's pipelined `(a+b)*c` multiply datapath. It takes a 40-bit signed product and a 17-bit signed factor, and recovers the 24-bit signed quotient (the original sum) and the remainder. Its job is to check and undo the multiply stage during loopback test and calibration. It is a one-bit-per-cycle restoring divider behind valid/ready handshakes, with fixed latency and saturation/divide-by-zero flags.

---
 rtl/mod3_div_if.sv | 27 ++
 rtl/mod3_div.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mod3_div_if.sv
// rtl/mod3_div_if.sv - operand/result handshake bundle for the sequential signed divider
interface mod3_div_if #(
    parameter int DW = 40,
    parameter int VW = 17,
    parameter int QW = 24
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] dividend;
    logic signed [VW-1:0] divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [QW-1:0] quotient;
    logic signed [VW-1:0] remainder;
    logic                 ovf;
    logic                 div0;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, div0
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, div0
    );
endinterface

// File: rtl/mod3_div.sv
// rtl/mod3_div.sv - one-bit-per-cycle signed restoring divider with saturation and div0 flags
module mod3_div #(
    parameter int DW = 40,
    parameter int VW = 17,
    parameter int QW = 24
) (
    input  logic clk,
    input  logic reset,
    mod3_div_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};
    localparam logic [DW-1:0] POS_LIMIT = {{(DW-QW){1'b0}}, Q_MAX};
    localparam logic [DW-1:0] NEG_LIMIT = {{(DW-QW){1'b0}}, Q_MIN};

    logic [2:0]    state;
    logic [DW-1:0] dvd_r;
    logic [VW-1:0] dvs_r;
    logic          sn_r;
    logic          sd_r;
    // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
    logic [DW-1:0] nq_r;
    logic [VW-1:0] mag_d_r;
    logic [VW-1:0] rem_r;
    logic [CW-1:0] cnt_r;

    logic [QW-1:0] q_o;
    logic [VW-1:0] r_o;
    logic          ovf_o;
    logic          div0_o;

    logic [VW:0]   shifted;
    logic [VW:0]   diff;
    logic          neg_q;
    logic [QW-1:0] q_lo;
    logic [VW-1:0] rem_mag;
    logic          sat_pos;
    logic          sat_neg;

    always_comb begin
        shifted = {rem_r, nq_r[DW-1]};
        diff    = shifted - {1'b0, mag_d_r};
        neg_q   = sn_r ^ sd_r;
        q_lo    = nq_r[QW-1:0];
        rem_mag = rem_r;
        sat_pos = !neg_q && (nq_r > POS_LIMIT);
        sat_neg = neg_q && (nq_r > NEG_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            dvd_r   <= '0;
            dvs_r   <= '0;
            sn_r    <= 1'b0;
            sd_r    <= 1'b0;
            nq_r    <= '0;
            mag_d_r <= '0;
            rem_r   <= '0;
            cnt_r   <= '0;
            q_o     <= '0;
            r_o     <= '0;
            ovf_o   <= 1'b0;
            div0_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        dvd_r <= bus.dividend;
                        dvs_r <= bus.divisor;
                        sn_r  <= bus.dividend[DW-1];
                        sd_r  <= bus.divisor[VW-1];
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    // Unsigned negation maps the most negative value onto its true magnitude.
                    nq_r    <= sn_r ? -dvd_r : dvd_r;
                    mag_d_r <= sd_r ? -dvs_r : dvs_r;
                    rem_r   <= '0;
                    cnt_r   <= CW'(DW);
                    state   <= S_DIV;
                end
                S_DIV: begin
                    rem_r <= diff[VW] ? shifted[VW-1:0] : diff[VW-1:0];
                    nq_r  <= {nq_r[DW-2:0], ~diff[VW]};
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (mag_d_r == '0) begin
                        div0_o <= 1'b1;
                        ovf_o  <= 1'b0;
                        r_o    <= '0;
                        q_o    <= sn_r ? Q_MIN : Q_MAX;
                    end else begin
                        div0_o <= 1'b0;
                        ovf_o  <= sat_pos | sat_neg;
                        r_o    <= sn_r ? -rem_mag : rem_mag;
                        if (sat_pos) begin
                            q_o <= Q_MAX;
                        end else if (sat_neg) begin
                            q_o <= Q_MIN;
                        end else begin
                            q_o <= neg_q ? -q_lo : q_lo;
                        end
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.quotient  = q_o;
    assign bus.remainder = r_o;
    assign bus.ovf       = ovf_o;
    assign bus.div0      = div0_o;
endmodule
